// File: rtl/counter_checker_if.sv
// Stimulus, DUT-observation and result bundle for counter_checker.
// slave is the checker side; master drives stimulus and reads results.
interface counter_checker_if;
   logic       enable;
   logic [1:0] mode;
   logic [3:0] D;
   logic [3:0] dut_Q;
   logic       dut_rco;
   logic       dut_load;
   logic [3:0] exp_Q;
   logic       exp_rco;
   logic       exp_load;
   logic       mismatch;
   logic       error_sticky;
   logic [7:0] err_count;
   logic [3:0] first_err_Q;
   logic [3:0] first_err_exp;
   logic [1:0] chk_state;

   modport slave (
      input  enable, mode, D, dut_Q, dut_rco, dut_load,
      output exp_Q, exp_rco, exp_load, mismatch, error_sticky, err_count,
             first_err_Q, first_err_exp, chk_state
   );

   modport master (
      output enable, mode, D, dut_Q, dut_rco, dut_load,
      input  exp_Q, exp_rco, exp_load, mismatch, error_sticky, err_count,
             first_err_Q, first_err_exp, chk_state
   );
endinterface

// File: rtl/counter_checker.sv
// Reference model of the 4-bit counter plus a compare/error tracker against the DUT.
// Model and mismatch are 1 cycle latency; no backpressure, every cycle is sampled.
module counter_checker #(
   parameter int         WARMUP  = 1,
   parameter logic [7:0] MAX_ERR = 8'd255
) (
   input  logic                  clk,
   input  logic                  reset,
   counter_checker_if.slave      bus
);

   localparam int WW = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;
   localparam logic [WW-1:0] WARM_LOAD = WARMUP[WW-1:0];

   typedef enum logic [1:0] {
      WARM  = 2'b01,
      CHECK = 2'b10,
      FAIL  = 2'b11
   } chk_state_e;

   chk_state_e      state_q, state_d;
   logic [WW-1:0]   warm_q, warm_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            rco_q, rco_d;
   logic            load_q, load_d;
   logic            mismatch_q, mismatch_d;
   logic            sticky_q, sticky_d;
   logic [7:0]      err_q, err_d;
   logic [3:0]      ferr_dut_q, ferr_dut_d;
   logic [3:0]      ferr_exp_q, ferr_exp_d;
   logic [4:0]      sum3;
   logic            miss;

   // Reference counter: tracks stimulus in every state, including FAIL.
   always_comb begin
      cnt_d  = cnt_q;
      rco_d  = 1'b0;
      load_d = 1'b0;
      sum3   = {1'b0, cnt_q} + 5'd3;
      if (bus.enable) begin
         case (bus.mode)
            2'b00: begin
               cnt_d = sum3[3:0];
               rco_d = sum3[4];
            end
            2'b01: begin
               cnt_d = cnt_q - 4'd1;
               rco_d = (cnt_q == 4'd0);
            end
            2'b10: begin
               cnt_d = cnt_q + 4'd1;
               rco_d = (cnt_q == 4'hF);
            end
            default: begin
               cnt_d  = bus.D;
               load_d = 1'b1;
            end
         endcase
      end
   end

   assign miss = (state_q == CHECK) &&
                 ({bus.dut_Q, bus.dut_rco, bus.dut_load} != {cnt_q, rco_q, load_q});

   always_comb begin
      state_d    = state_q;
      warm_d     = warm_q;
      mismatch_d = 1'b0;
      sticky_d   = sticky_q;
      err_d      = err_q;
      ferr_dut_d = ferr_dut_q;
      ferr_exp_d = ferr_exp_q;
      case (state_q)
         WARM: begin
            if (warm_q == '0) state_d = CHECK;
            else              warm_d  = warm_q - WW'(1);
         end
         CHECK: begin
            mismatch_d = miss;
            if (miss) begin
               sticky_d = 1'b1;
               if (err_q < MAX_ERR) err_d = err_q + 8'd1;
               if (!sticky_q) begin
                  ferr_dut_d = bus.dut_Q;
                  ferr_exp_d = cnt_q;
               end
               // The miss that reaches the limit is counted and trips FAIL together.
               if (err_d == MAX_ERR) state_d = FAIL;
            end
         end
         FAIL: state_d = FAIL;
         default: begin
            state_d = WARM;
            warm_d  = WARM_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= WARM;
         warm_q     <= WARM_LOAD;
         cnt_q      <= 4'd0;
         rco_q      <= 1'b0;
         load_q     <= 1'b0;
         mismatch_q <= 1'b0;
         sticky_q   <= 1'b0;
         err_q      <= 8'd0;
         ferr_dut_q <= 4'd0;
         ferr_exp_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         warm_q     <= warm_d;
         cnt_q      <= cnt_d;
         rco_q      <= rco_d;
         load_q     <= load_d;
         mismatch_q <= mismatch_d;
         sticky_q   <= sticky_d;
         err_q      <= err_d;
         ferr_dut_q <= ferr_dut_d;
         ferr_exp_q <= ferr_exp_d;
      end
   end

   assign bus.exp_Q         = cnt_q;
   assign bus.exp_rco       = rco_q;
   assign bus.exp_load      = load_q;
   assign bus.mismatch      = mismatch_q;
   assign bus.error_sticky  = sticky_q;
   assign bus.err_count     = err_q;
   assign bus.first_err_Q   = ferr_dut_q;
   assign bus.first_err_exp = ferr_exp_q;
   assign bus.chk_state     = state_q;

endmodule

// File: doc/counter_checker.md
COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 The module SHALL have parameter WARMUP, default 1, meaning the number of cycles after reset release before comparison starts (0 allowed).
REQ-002 The module SHALL have parameter MAX_ERR, default 8'd255, meaning the mismatch count at which checking stops.
REQ-003 The module SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-low reset: reset==0 at a rising clk edge resets the block.
REQ-005 The module SHALL have port enable  input  1  stimulus enable, the same value driven to the DUT.
REQ-006 The module SHALL have port mode  input  2  stimulus mode, the same value driven to the DUT.
REQ-007 The module SHALL have port D  input  4  stimulus load data, the same value driven to the DUT.
REQ-008 The module SHALL have ports dut_Q  input  4, dut_rco  input  1 and dut_load  input  1, carrying the registered outputs of the counter under test.
REQ-009 The module SHALL have ports exp_Q  output  4, exp_rco  output  1 and exp_load  output  1, carrying the registered reference-model outputs.
REQ-010 The module SHALL have port mismatch  output  1  registered one-cycle pulse per failing compare.
REQ-011 The module SHALL have port error_sticky  output  1  set on the first mismatch and held until reset.
REQ-012 The module SHALL have port err_count  output  8  number of mismatches, saturating at MAX_ERR.
REQ-013 The module SHALL have ports first_err_Q  output  4 and first_err_exp  output  4, capturing dut_Q and exp_Q at the first mismatch.
REQ-014 The module SHALL have port chk_state  output  2  encoded as WARM=2'b01, CHECK=2'b10, FAIL=2'b11.

Function
REQ-015 The reference model SHALL update exp_Q, exp_rco and exp_load at each rising edge from enable, mode and D, with the same timing as the DUT.
REQ-016 When enable==0, the model SHALL hold exp_Q and set exp_rco=0 and exp_load=0.
REQ-017 When enable==1 and mode==00, the model SHALL set exp_Q=(exp_Q+3) mod 16 and exp_rco=1 iff exp_Q+3>15.
REQ-018 When enable==1 and mode==01, the model SHALL set exp_Q=(exp_Q-1) mod 16 and exp_rco=1 iff exp_Q==0 before the update.
REQ-019 When enable==1 and mode==10, the model SHALL set exp_Q=(exp_Q+1) mod 16 and exp_rco=1 iff exp_Q==15 before the update.
REQ-020 When enable==1 and mode==11, the model SHALL set exp_Q=D, exp_load=1 and exp_rco=0.
REQ-021 For any mode other than 11, the model SHALL drive exp_load=0.
REQ-022 Compare rule: at a rising edge in CHECK, the block SHALL form a miss when {dut_Q,dut_rco,dut_load} differs from {exp_Q,exp_rco,exp_load} as currently registered; mismatch SHALL equal that miss on the following cycle (latency 1).
REQ-023 On every miss, err_count SHALL increment by 1, saturating at MAX_ERR.
REQ-024 On every miss, error_sticky SHALL be set to 1.
REQ-025 On a miss while error_sticky==0, first_err_Q and first_err_exp SHALL be captured; later misses SHALL NOT overwrite them.
REQ-026 State machine: the block SHALL enter WARM on reset with its warm-up counter loaded to WARMUP.
REQ-027 In WARM, the warm-up counter SHALL decrement each cycle; WARM SHALL go to CHECK on the edge where the counter is 0, so WARMUP=0 gives CHECK on the first edge after release.
REQ-028 The block SHALL NOT compare in WARM; mismatch SHALL be 0 there.
REQ-029 CHECK SHALL go to FAIL on the edge where err_count becomes MAX_ERR.
REQ-030 In FAIL, comparison SHALL stop: mismatch=0 and err_count, first_err_* and error_sticky frozen, while the model keeps tracking stimulus.
REQ-031 FAIL SHALL be left only by reset.
REQ-032 A simultaneous miss and MAX_ERR crossing SHALL both count that miss and enter FAIL on the same edge.

Reset
REQ-033 When reset==0 at a rising edge, the block SHALL set exp_Q=0, exp_rco=0, exp_load=0, mismatch=0, error_sticky=0, err_count=0, first_err_Q=0, first_err_exp=0 and chk_state=WARM.
REQ-034 A reset asserted mid-CHECK or in FAIL SHALL clear all state on that edge, with no partial compare recorded.

Verification
REQ-035 Reset held 0 for 3 cycles, dut outputs 0, WARMUP=1 -> all outputs 0 during reset; chk_state WARM then CHECK 2 cycles after release; mismatch=0.
REQ-036 enable=1, mode=10 from Q=0 for 16 cycles, correct DUT -> exp_Q steps 1..15,0; exp_rco=1 only on the cycle exp_Q wraps 15->0; mismatch=0 and err_count=0 throughout.
REQ-037 mode=00 from exp_Q=14 -> exp_Q=1 with exp_rco=1; mode=01 from exp_Q=0 -> exp_Q=15 with exp_rco=1.
REQ-038 dut_Q=5 driven while exp_Q=4 -> mismatch=1 for one cycle, error_sticky=1, err_count=1, first_err_Q=5, first_err_exp=4.
REQ-039 mode=11 with D=9 and dut_load stuck 0 -> exp_Q=9 and exp_load=1 with mismatch; with MAX_ERR=3 and continuous misses, chk_state=FAIL after the 3rd miss and err_count stays 3.
REQ-040 reset=0 for one edge while in FAIL with error_sticky=1 -> all outputs reset per REQ-033, chk_state=WARM.
